// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the 8-bit CPU control sequencer: opcodes, widths, state encoding.
package cpu_sequencer_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OP_W       = 4;

  localparam logic [OP_W-1:0] OP_LOAD = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_INP  = 4'h4;
  localparam logic [OP_W-1:0] OP_OUTP = 4'h5;
  localparam logic [OP_W-1:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_IO_WAIT = 3'd3,
    ST_EXEC    = 3'd4,
    ST_HALT    = 3'd5
  } seq_state_e;

  function automatic logic is_io_op(input logic [OP_W-1:0] op);
    return (op == OP_INP) || (op == OP_OUTP);
  endfunction

  // Anything outside the defined opcode set executes as a NOP and is flagged
  function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
    logic ill;
    case (op)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_INP, OP_OUTP, OP_HLT: ill = 1'b0;
      default:                                                  ill = 1'b1;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/cpu_sequencer_prog_counter.sv
// Program counter: async clear, increment enable, natural wrap modulo 2**ADDR_W.
module cpu_sequencer_prog_counter #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control sequencer; owns PC and IR, drives d/e strobes and I/O handshake.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] ir,
  output logic              d,
  output logic              e,
  output logic              io_req,
  input  logic              io_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              mem_rd_q, mem_rd_d;
  logic              d_q, d_d;
  logic              e_q, e_d;
  logic              io_req_q, io_req_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_val;
  logic [OP_W-1:0]   op;

  assign op = ir_q[DATA_W-1 -: OP_W];

  cpu_sequencer_prog_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pc_inc),
    .pc   (pc_val)
  );

  // Next-state logic; strobes are decoded from the next state so they register cleanly
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_inc  = 1'b0;
    case (state_q)
      ST_IDLE:    if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        ir_d    = mem_rdata;
        pc_inc  = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (op == OP_HLT)      state_d = ST_HALT;
        else if (is_io_op(op)) state_d = ST_IO_WAIT;
        else                   state_d = ST_EXEC;
      end
      ST_IO_WAIT: if (io_ack) state_d = ST_EXEC;
      ST_EXEC:    state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT:    if (!run) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    mem_rd_d  = (state_d == ST_FETCH);
    d_d       = (state_d == ST_DECODE);
    e_d       = (state_d == ST_EXEC);
    io_req_d  = (state_d == ST_IO_WAIT);
    halted_d  = (state_d == ST_HALT);
    illegal_d = (state_d == ST_EXEC) && is_illegal_op(op);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      mem_rd_q  <= 1'b0;
      d_q       <= 1'b0;
      e_q       <= 1'b0;
      io_req_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      mem_rd_q  <= mem_rd_d;
      d_q       <= d_d;
      e_q       <= e_d;
      io_req_q  <= io_req_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_addr = pc_val;
  assign pc       = pc_val;
  assign ir       = ir_q;
  assign mem_rd   = mem_rd_q;
  assign d        = d_q;
  assign e        = e_q;
  assign io_req   = io_req_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues expected d/e events, a monitor checks them.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] mem_rdata;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic [7:0] ir;
  logic       d, e, io_req, io_ack, halted, illegal;
  logic [3:0] pc;

  logic [7:0] mem [16];

  typedef struct {
    bit         is_e;
    logic [7:0] ir;
    logic [3:0] pc;
    bit         ill;
    bit         chk_lat;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  fetch_cyc = 0;

  cpu_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .ir       (ir),
    .d        (d),
    .e        (e),
    .io_req   (io_req),
    .io_ack   (io_ack),
    .pc       (pc),
    .halted   (halted),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_e, input logic [7:0] i, input logic [3:0] p,
                      input bit ill, input bit lat);
    ev_t ev;
    ev.is_e = is_e; ev.ir = i; ev.pc = p; ev.ill = ill; ev.chk_lat = lat;
    exp_q.push_back(ev);
  endtask

  // Non-IO instruction: decode then execute two cycles after its fetch
  task automatic push_instr(input logic [7:0] i, input logic [3:0] p, input bit ill);
    push(1'b0, i, p, 1'b0, 1'b0);
    push(1'b1, i, p, ill, 1'b1);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    run    = 1'b0;
    io_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_halt(input string name, input int max);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(halted), 32'd1);
  endtask

  // Monitor: every d or e pulse must match the next queued expectation
  always @(negedge clk) begin
    ev_t ev;
    if (rst_n) begin
      cyc++;
      if (mem_rd) fetch_cyc = cyc;
      if (d) chk("d_e_exclusive", 32'(e), 32'd0);
      if (e) chk("e_while_io_req", 32'(io_req), 32'd0);
      if (illegal) chk("illegal_only_with_e", 32'(e), 32'd1);
      if (d || e) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got d=%0b e=%0b ir=0x%0h required none", d, e, ir);
        end else begin
          ev = exp_q.pop_front();
          chk("strobe_kind_e", 32'(e), 32'(ev.is_e));
          chk("strobe_ir", 32'(ir), 32'(ev.ir));
          chk("strobe_pc", 32'(pc), 32'(ev.pc));
          if (e) chk("exec_illegal", 32'(illegal), 32'(ev.ill));
          if (ev.chk_lat) chk("exec_latency", 32'(cyc - fetch_cyc), 32'd2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset state
    do_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_e", 32'(e), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_io_req", 32'(io_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Straight-line program ending in HLT; io_ack held high must be ignored
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'hF0;
    push_instr(8'h10, 4'd1, 1'b0);
    push_instr(8'h20, 4'd2, 1'b0);
    push_instr(8'h30, 4'd3, 1'b0);
    push(1'b0, 8'hF0, 4'd4, 1'b0, 1'b0);
    io_ack = 1'b1;
    run = 1'b1;
    wait_halt("line_halt", 50);
    io_ack = 1'b0;
    chk("line_halt_pc", 32'(pc), 32'd4);
    chk("line_halt_ir", 32'(ir), 32'hF0);
    repeat (3) @(negedge clk);
    chk("line_halt_held", 32'(halted), 32'd1);
    chk("line_halt_pc_frozen", 32'(pc), 32'd4);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("line_unhalt", 32'(halted), 32'd0);

    // IO stall: io_ack low for 5 cycles of io_req, then high
    do_reset();
    mem[0] = 8'h40; mem[1] = 8'hF0;
    push(1'b0, 8'h40, 4'd1, 1'b0, 1'b0);
    push(1'b1, 8'h40, 4'd1, 1'b0, 1'b0);
    push(1'b0, 8'hF0, 4'd2, 1'b0, 1'b0);
    run = 1'b1;
    n = 0;
    while (!io_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("io_req_rise", 32'(io_req), 32'd1);
    n = 1;
    io_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!io_req) break;
      n++;
      io_ack = (n >= 6);
    end
    chk("io_req_cycles", 32'(n), 32'd6);
    chk("io_exec_after_ack", 32'(e), 32'd1);
    io_ack = 1'b0;
    wait_halt("io_halt", 20);
    chk("io_halt_pc", 32'(pc), 32'd2);
    run = 1'b0;
    @(negedge clk);

    // Illegal opcode executes as NOP with illegal flagged alongside e
    do_reset();
    mem[0] = 8'h70; mem[1] = 8'hF0;
    push_instr(8'h70, 4'd1, 1'b1);
    push(1'b0, 8'hF0, 4'd2, 1'b0, 1'b0);
    run = 1'b1;
    wait_halt("ill_halt", 20);
    chk("ill_halt_pc", 32'(pc), 32'd2);
    run = 1'b0;
    @(negedge clk);

    // Run through to pc=F, drop run during decode of the last word, expect wrap to 0
    do_reset();
    for (int i = 0; i < 15; i++) mem[i] = 8'h00;
    mem[15] = 8'h10;
    for (int i = 0; i < 15; i++) push_instr(8'h00, 4'(i + 1), 1'b0);
    push_instr(8'h10, 4'd0, 1'b0);
    run = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (d && ir == 8'h10) begin
        found = 1'b1;
        break;
      end
    end
    chk("wrap_decode_seen", 32'(found), 32'd1);
    run = 1'b0;
    repeat (4) @(negedge clk);
    chk("wrap_idle_mem_rd", 32'(mem_rd), 32'd0);
    chk("wrap_idle_pc", 32'(pc), 32'd0);
    mem[1] = 8'hF0;
    push_instr(8'h00, 4'd1, 1'b0);
    push(1'b0, 8'hF0, 4'd2, 1'b0, 1'b0);
    run = 1'b1;
    n = 0;
    while (!mem_rd && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wrap_refetch_rd", 32'(mem_rd), 32'd1);
    chk("wrap_refetch_addr", 32'(mem_addr), 32'd0);
    wait_halt("wrap_halt", 20);
    run = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of IO_WAIT
    do_reset();
    mem[0] = 8'h40;
    push(1'b0, 8'h40, 4'd1, 1'b0, 1'b0);
    run = 1'b1;
    n = 0;
    while (!io_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_io_req_up", 32'(io_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rstmid_io_req_async", 32'(io_req), 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_pc", 32'(pc), 32'd0);
    chk("rstmid_ir", 32'(ir), 32'd0);
    chk("rstmid_idle_rd", 32'(mem_rd), 32'd0);
    chk("rstmid_idle_io_req", 32'(io_req), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
